// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the serial DAC writer.
package dac_spi_pkg;

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned CMD_W      = 8;
  localparam int unsigned CODE_W     = 16;
  localparam int unsigned BIT_CNT_W  = 5;
  localparam int unsigned FCNT_W     = 16;
  localparam int unsigned OVR_W      = 8;

  localparam logic [CMD_W-1:0] DEFAULT_CMD = 8'h30;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LDAC
  } state_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [CODE_W-1:0] data;
  } frame_t;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (v == {OVR_W{1'b1}}) ? v : v + OVR_W'(1);
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SPI clock divider: toggles sclk every HALF_DIV enabled cycles and flags the
// edge that is about to happen so the FSM can act on the same clk edge.
module dac_sclk_gen #(
  parameter int unsigned HALF_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise_tick_c,
  output logic fall_tick_c
);

  localparam int unsigned DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap_c;

  assign wrap_c      = en && !clr && (div_cnt == DIV_LAST);
  assign rise_tick_c = wrap_c && !sclk;
  assign fall_tick_c = wrap_c && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk    <= 1'b0;
      div_cnt <= '0;
    end else if (clr) begin
      sclk    <= 1'b0;
      div_cnt <= '0;
    end else if (en) begin
      if (wrap_c) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/dac_spi_writer.sv
// Serial DAC driver: buffers the latest code (latest-wins) and ships it as a
// 24-bit SPI frame {CMD_WORD, code}, followed by an LDAC pulse.
module dac_spi_writer
  import dac_spi_pkg::*;
#(
  parameter int unsigned      HALF_DIV = 1,
  parameter logic [CMD_W-1:0] CMD_WORD = DEFAULT_CMD,
  parameter int unsigned      LDAC_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code,
  input  logic              load,
  input  logic              auto_mode,
  output logic              sclk,
  output logic              sdi,
  output logic              cs_n,
  output logic              ldac_n,
  output logic              busy,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [OVR_W-1:0]  overrun_cnt
);

  localparam int unsigned WAIT_MAX = (LDAC_W > HALF_DIV) ? LDAC_W : HALF_DIV;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0]    HOLD_LAST = WAIT_W'(HALF_DIV - 1);
  localparam logic [WAIT_W-1:0]    LDAC_LAST = WAIT_W'(LDAC_W);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [CODE_W-1:0]       pend_data_q, pend_data_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [CODE_W-1:0]       last_cap_q, last_cap_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                    sdi_d, cs_n_d, ldac_n_d, busy_d, frame_done_d;
  logic [FCNT_W-1:0]       frame_cnt_d;
  logic [OVR_W-1:0]        overrun_cnt_d;

  logic   sclk_en_c, sclk_clr_c, rise_tick_c, fall_tick_c;
  logic   auto_cap_c, cap_c, consume_c;
  frame_t frame_c;

  assign sclk_en_c  = (state_q == SETUP) || (state_q == SHIFT);
  assign sclk_clr_c = (state_q == LDAC) && (wait_cnt_q == LDAC_LAST);

  dac_sclk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .rst         (rst),
    .en          (sclk_en_c),
    .clr         (sclk_clr_c),
    .sclk        (sclk),
    .rise_tick_c (rise_tick_c),
    .fall_tick_c (fall_tick_c)
  );

  // Pending buffer, auto-mode compare and frame sequencing.
  always_comb begin
    state_d       = state_q;
    pend_data_d   = pend_data_q;
    pend_valid_d  = pend_valid_q;
    last_cap_d    = last_cap_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    sdi_d         = sdi;
    cs_n_d        = cs_n;
    ldac_n_d      = ldac_n;
    busy_d        = busy;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt;
    overrun_cnt_d = overrun_cnt;

    auto_cap_c = auto_mode && (code != last_cap_q);
    cap_c      = auto_mode ? auto_cap_c : load;
    consume_c  = (state_q == IDLE) && pend_valid_q;
    frame_c    = '{cmd: CMD_WORD, data: pend_data_q};

    if (auto_cap_c) last_cap_d = code;
    if (consume_c)  pend_valid_d = 1'b0;
    // A code consumed on this edge is not an overrun; the new one just queues.
    if (cap_c) begin
      pend_data_d  = code;
      pend_valid_d = 1'b1;
      if (pend_valid_q && !consume_c) overrun_cnt_d = sat_inc(overrun_cnt);
    end

    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          shreg_d   = frame_c;
          sdi_d     = frame_c.cmd[CMD_W-1];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (rise_tick_c) state_d = SHIFT;
      end
      SHIFT: begin
        if (fall_tick_c) begin
          if (bit_cnt_q == BIT_LAST) begin
            wait_cnt_d = '0;
            state_d    = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            sdi_d     = shreg_q[FRAME_BITS-2];
            shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (wait_cnt_q == HOLD_LAST) begin
          cs_n_d     = 1'b1;
          wait_cnt_d = '0;
          state_d    = LDAC;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      LDAC: begin
        if (wait_cnt_q == LDAC_LAST) begin
          ldac_n_d     = 1'b1;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt + FCNT_W'(1);
          state_d      = IDLE;
        end else begin
          ldac_n_d   = 1'b0;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      last_cap_q   <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      sdi          <= 1'b0;
      cs_n         <= 1'b1;
      ldac_n       <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      overrun_cnt  <= '0;
    end else begin
      state_q      <= state_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      last_cap_q   <= last_cap_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      sdi          <= sdi_d;
      cs_n         <= cs_n_d;
      ldac_n       <= ldac_n_d;
      busy         <= busy_d;
      frame_done   <= frame_done_d;
      frame_cnt    <= frame_cnt_d;
      overrun_cnt  <= overrun_cnt_d;
    end
  end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Directed bench for dac_spi_writer: transaction-level expectation queue checked
// against frames decoded off the SPI pins, plus timing checks on a slow instance.
module tb_dac_spi_writer;

  localparam int FRAME_PERIOD = 49 * 1 + 2 + 2;

  logic        clk, rst;
  logic [15:0] code, code3;
  logic        load, load3, auto_mode;
  logic        sclk, sdi, cs_n, ldac_n, busy, frame_done;
  logic [15:0] frame_cnt;
  logic [7:0]  overrun_cnt;
  logic        sclk3, sdi3, cs_n3, ldac_n3, busy3, frame_done3;
  logic [15:0] frame_cnt3;
  logic [7:0]  overrun_cnt3;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ldac_total = 0;

  dac_spi_writer u_dut (
    .clk(clk), .rst(rst), .code(code), .load(load), .auto_mode(auto_mode),
    .sclk(sclk), .sdi(sdi), .cs_n(cs_n), .ldac_n(ldac_n), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
  );

  dac_spi_writer #(.HALF_DIV(3), .CMD_WORD(8'h30), .LDAC_W(1)) u_dut3 (
    .clk(clk), .rst(rst), .code(code3), .load(load3), .auto_mode(1'b0),
    .sclk(sclk3), .sdi(sdi3), .cs_n(cs_n3), .ldac_n(ldac_n3), .busy(busy3),
    .frame_done(frame_done3), .frame_cnt(frame_cnt3), .overrun_cnt(overrun_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction model: predicts which code each frame carries and the overrun count.
  logic [23:0] exp_q[$];
  logic [15:0] m_pend, m_last;
  logic        m_pend_v, m_ld;
  int          m_ovr, m_edge, m_idle_at;

  initial begin
    m_pend = '0; m_last = '0; m_pend_v = 1'b0; m_ovr = 0; m_edge = 0; m_idle_at = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_pend_v = 1'b0; m_last = '0; m_ovr = 0; m_idle_at = 0;
      exp_q.delete();
    end else begin
      m_ld = auto_mode ? (code != m_last) : load;
      if (auto_mode && code != m_last) m_last = code;
      if (m_edge >= m_idle_at && m_pend_v) begin
        exp_q.push_back({8'h30, m_pend});
        m_pend_v  = 1'b0;
        m_idle_at = m_edge + FRAME_PERIOD;
      end
      if (m_ld) begin
        if (m_pend_v && m_ovr < 255) m_ovr++;
        m_pend   = code;
        m_pend_v = 1'b1;
      end
    end
    m_edge++;
  end

  // Pin monitor: decodes each frame and pops the expectation when it completes.
  logic [23:0] mon_bits, last_rx;
  int          mon_n, cs_low, ldac_low, stab_bad;
  logic        prev_sclk, prev_sdi;

  always @(negedge clk) begin
    if (rst) begin
      mon_bits = '0; mon_n = 0; cs_low = 0; ldac_low = 0; stab_bad = 0;
      prev_sclk = 1'b0; prev_sdi = 1'b0;
    end else begin
      if (!prev_sclk && sclk) begin
        mon_bits = {mon_bits[22:0], sdi};
        mon_n++;
        if (sdi !== prev_sdi) stab_bad++;
      end
      if (!cs_n) cs_low++;
      if (!ldac_n) begin ldac_low++; ldac_total++; end
      if (frame_done) begin
        done_cnt++;
        check("bits_per_frame", 32'(mon_n), 32'd24);
        check("cs_low_cycles", 32'(cs_low), 32'd49);
        check("ldac_low_cycles", 32'(ldac_low), 32'd2);
        check("sdi_setup_stable", 32'(stab_bad), 32'd0);
        check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("frame_data", 32'(mon_bits), 32'(exp_q.pop_front()));
        last_rx = mon_bits;
        mon_n = 0; cs_low = 0; ldac_low = 0; stab_bad = 0;
      end
      prev_sclk = sclk;
      prev_sdi  = sdi;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, 32'(sclk), 32'd0);
    check({tag, "_sdi"}, 32'(sdi), 32'd0);
    check({tag, "_cs_n"}, 32'(cs_n), 32'd1);
    check({tag, "_ldac_n"}, 32'(ldac_n), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_overrun_cnt"}, 32'(overrun_cnt), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; code = '0; load = 1'b0; auto_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
  endtask

  task automatic pulse_load(input logic [15:0] c);
    code = c; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int nr, r1, r2, cl, bh, i;
    logic ps, got_done;
    logic [23:0] bits3;
    logic [15:0] last_code;

    rst = 1'b1; code = '0; load = 1'b0; auto_mode = 1'b0; code3 = '0; load3 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    check("por_cs_n3", 32'(cs_n3), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single frame: latency, content, pulse widths, counters.
    pulse_load(16'hA5C3);
    check("lat_cs_n_t", 32'(cs_n), 32'd1);
    @(negedge clk);
    check("lat_cs_n_t1", 32'(cs_n), 32'd0);
    check("lat_busy_t1", 32'(busy), 32'd1);
    check("lat_sdi_bit23", 32'(sdi), 32'd0);
    repeat (70) @(negedge clk);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_done_pulses", 32'(done_cnt), 32'd1);
    check("t1_rx", 32'(last_rx), 32'h30A5C3);
    check("t1_overrun", 32'(overrun_cnt), 32'd0);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // Latest-wins buffering during a frame.
    do_reset();
    pulse_load(16'h0001);
    repeat (9) @(negedge clk);
    pulse_load(16'h0002);
    repeat (9) @(negedge clk);
    pulse_load(16'h0003);
    repeat (130) @(negedge clk);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd2);
    check("t2_overrun", 32'(overrun_cnt), 32'd1);
    check("t2_rx_last", 32'(last_rx), 32'h300003);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Auto mode: only changes of code produce frames.
    do_reset();
    auto_mode = 1'b1; code = 16'h0000;
    repeat (44) @(negedge clk);
    check("t3_zero_not_sent", 32'(busy), 32'd0);
    code = 16'h0001;
    repeat (44) @(negedge clk);
    code = 16'h0002;
    repeat (200) @(negedge clk);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd2);
    check("t3_rx_last", 32'(last_rx), 32'h300002);
    check("t3_overrun", 32'(overrun_cnt), 32'd0);
    repeat (100) @(negedge clk);
    check("t3_no_more_frames", 32'(frame_cnt), 32'd2);
    check("t3_idle", 32'(busy), 32'd0);
    auto_mode = 1'b0;

    // Slow instance: HALF_DIV=3, LDAC_W=1.
    do_reset();
    code3 = 16'hFFFF; load3 = 1'b1;
    @(negedge clk);
    load3 = 1'b0;
    nr = 0; r1 = 0; r2 = 0; cl = 0; bh = 0; ps = 1'b0; got_done = 1'b0; bits3 = '0; i = 0;
    while (i < 400 && !got_done) begin
      @(negedge clk);
      if (!cs_n3) cl++;
      if (busy3) bh++;
      if (sclk3 && !ps) begin
        bits3 = {bits3[22:0], sdi3};
        nr++;
        if (nr == 1) r1 = i;
        if (nr == 2) r2 = i;
      end
      ps = sclk3;
      if (frame_done3) got_done = 1'b1;
      i++;
    end
    check("t4_done_seen", 32'(got_done), 32'd1);
    check("t4_sclk_period", 32'(r2 - r1), 32'd6);
    check("t4_cs_low", 32'(cl), 32'd147);
    check("t4_busy_high", 32'(bh), 32'd149);
    check("t4_bits", 32'(bits3), 32'h30FFFF);
    check("t4_rises", 32'(nr), 32'd24);
    check("t4_frame_cnt", 32'(frame_cnt3), 32'd1);

    // Reset in the middle of a frame.
    do_reset();
    ldac_total = 0;
    pulse_load(16'h1234);
    nr = 0; ps = sclk; i = 0;
    while (i < 200 && nr < 10) begin
      @(posedge clk);
      #1;
      if (sclk && !ps) nr++;
      ps = sclk;
      i++;
    end
    check("t5_tenth_rise_seen", 32'(nr), 32'd10);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_no_ldac", 32'(ldac_total), 32'd0);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t5_pend_cleared", 32'(cs_n), 32'd1);
    check("t5_done_cnt", 32'(done_cnt), 32'd0);

    // Back-to-back loads: overrun saturation and latest code delivered.
    do_reset();
    last_code = '0;
    for (int k = 0; k < 300; k++) begin
      last_code = 16'($urandom);
      code = last_code; load = 1'b1;
      @(negedge clk);
    end
    load = 1'b0;
    repeat (150) @(negedge clk);
    check("t6_overrun_sat", 32'(overrun_cnt), 32'hFF);
    check("t6_overrun_model", 32'(overrun_cnt), 32'(m_ovr));
    check("t6_last_sent", 32'(last_rx), 32'({8'h30, last_code}));
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
